// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the pixel pipeline and VGA pins.
//
// A divide-by-DIV strobe (DIV = clk_mhz / pixel_mhz) paces a horizontal and a
// vertical position counter. All outputs are registered and decoded from the
// next counter values, so they line up with the position on the same clk.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-low
//   pixel_en    out  1-clk strobe every DIV clks; high in the last clk of a position
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   display_on  out  position is inside the active area
//   x, y        out  active-area column/row, 0 outside the active area
//   frame_cnt   out  frames completed, mod 2^16 (only with VGA_FRAME_CNT_EN)
//
// Build option
//   VGA_FRAME_CNT_EN  adds the frame_cnt port and its counter.
module vga_timing_gen #(
    parameter int unsigned clk_mhz       = 50,
    parameter int unsigned pixel_mhz     = 25,
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned h_front_porch = 16,
    parameter int unsigned h_sync_pulse  = 96,
    parameter int unsigned h_back_porch  = 48,
    parameter int unsigned v_front_porch = 10,
    parameter int unsigned v_sync_pulse  = 2,
    parameter int unsigned v_back_porch  = 33,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           pixel_en,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic [w_x-1:0] x,
    output logic [w_y-1:0] y
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    localparam int unsigned PIX_SAFE = (pixel_mhz == 0) ? 1 : pixel_mhz;
    localparam int unsigned DIV      = clk_mhz / PIX_SAFE;
    localparam int unsigned H_TOTAL  = screen_width + h_front_porch + h_sync_pulse + h_back_porch;
    localparam int unsigned V_TOTAL  = screen_height + v_front_porch + v_sync_pulse + v_back_porch;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HS_START = screen_width + h_front_porch;
    localparam int unsigned HS_END   = HS_START + h_sync_pulse;
    localparam int unsigned VS_START = screen_height + v_front_porch;
    localparam int unsigned VS_END   = VS_START + v_sync_pulse;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    if ((pixel_mhz == 0) || (clk_mhz < pixel_mhz) || ((clk_mhz % PIX_SAFE) != 0)) begin : g_bad_div
        $error("vga_timing_gen: clk_mhz/pixel_mhz must be an integer >= 1");
    end

    logic [DW-1:0]  div_q, div_d;
    logic           pe_q, pe_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [w_x-1:0] x_q, x_d;
    logic [w_y-1:0] y_q, y_d;
    logic [31:0]    h_ext, v_ext;

    // pe_q is registered one clk behind the divider compare, so the strobe is
    // high during the last clk of a position and the counters step on the edge
    // that ends it. This also keeps (0,0) on screen for DIV clks after reset.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pe_d  = (div_q == DIV_LAST);
        h_d   = h_q;
        v_d   = v_q;
        if (pe_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        h_ext   = 32'(h_d);
        v_ext   = 32'(v_d);
        de_d    = (h_ext < screen_width) && (v_ext < screen_height);
        hsync_d = !((h_ext >= HS_START) && (h_ext < HS_END));
        vsync_d = !((v_ext >= VS_START) && (v_ext < VS_END));
        x_d     = de_d ? h_d[w_x-1:0] : '0;
        y_d     = de_d ? v_d[w_y-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            pe_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            div_q   <= div_d;
            pe_q    <= pe_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign pixel_en   = pe_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = de_q;
    assign x          = x_q;
    assign y          = y_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // A frame completes on the strobe where both counters wrap to (0,0).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pe_q && (h_q == H_LAST) && (v_q == V_LAST)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (full 640x480 at DIV=2, and a small
// raster at DIV=1/2/3) compared every clk against an arithmetic raster model
// driven by the number of clks since reset release, plus literal pins.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned SW = 20, SH = 12;
    localparam int unsigned SHFP = 3, SHS = 4, SHBP = 5;
    localparam int unsigned SVFP = 2, SVS = 2, SVBP = 3;
    localparam longint unsigned SFR = 608; // 32 * 19 pixels per small frame

    typedef struct packed {
        logic        pe;
        logic        hs;
        logic        vs;
        logic        de;
        logic [31:0] x;
        logic [31:0] y;
        logic [15:0] fc;
    } obs_t;

    // full-size instance (a_), small raster at DIV=2 (b_), DIV=1 (c_), DIV=3 (d_)
    logic       a_pe, a_hs, a_vs, a_de;
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic       b_pe, b_hs, b_vs, b_de, c_pe, c_hs, c_vs, c_de, d_pe, d_hs, d_vs, d_de;
    logic [4:0] b_x, c_x, d_x;
    logic [3:0] b_y, c_y, d_y;
    logic [15:0] a_fc, b_fc, c_fc, d_fc;

    vga_timing_gen #(.clk_mhz(50), .pixel_mhz(25)) u_full (
        .clk(clk), .rst(rst), .pixel_en(a_pe), .hsync(a_hs), .vsync(a_vs),
        .display_on(a_de), .x(a_x), .y(a_y)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing_gen #(.clk_mhz(50), .pixel_mhz(25), .screen_width(SW), .screen_height(SH),
        .h_front_porch(SHFP), .h_sync_pulse(SHS), .h_back_porch(SHBP),
        .v_front_porch(SVFP), .v_sync_pulse(SVS), .v_back_porch(SVBP)) u_small (
        .clk(clk), .rst(rst), .pixel_en(b_pe), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_de), .x(b_x), .y(b_y)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_timing_gen #(.clk_mhz(25), .pixel_mhz(25), .screen_width(SW), .screen_height(SH),
        .h_front_porch(SHFP), .h_sync_pulse(SHS), .h_back_porch(SHBP),
        .v_front_porch(SVFP), .v_sync_pulse(SVS), .v_back_porch(SVBP)) u_div1 (
        .clk(clk), .rst(rst), .pixel_en(c_pe), .hsync(c_hs), .vsync(c_vs),
        .display_on(c_de), .x(c_x), .y(c_y)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

    vga_timing_gen #(.clk_mhz(75), .pixel_mhz(25), .screen_width(SW), .screen_height(SH),
        .h_front_porch(SHFP), .h_sync_pulse(SHS), .h_back_porch(SHBP),
        .v_front_porch(SVFP), .v_sync_pulse(SVS), .v_back_porch(SVBP)) u_div3 (
        .clk(clk), .rst(rst), .pixel_en(d_pe), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .x(d_x), .y(d_y)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_fc = '0;
    assign b_fc = '0;
    assign c_fc = '0;
    assign d_fc = '0;
`endif

    int unsigned     n_vec = 0, n_err = 0;
    longint unsigned k = 0;       // clk edges since reset released; 0 while in reset
    longint unsigned fc_off = 0;  // frame_cnt preload seen by u_small
    int unsigned     pe_cnt = 0, hs_lo = 0;

    always @(posedge clk) k <= rst ? k + 64'd1 : 64'd0;

    // Position index p = (k-1)/div; h, v, frame follow by division.
    function automatic obs_t model(input longint unsigned div, w, hfp, hsp, hbp,
                                   hh, vfp, vsp, vbp, kk, off);
        obs_t o;
        longint unsigned p, ht, vt, h, v;
        o = '0;
        if (kk == 0) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            return o;
        end
        ht   = w + hfp + hsp + hbp;
        vt   = hh + vfp + vsp + vbp;
        p    = (kk - 1) / div;
        h    = p % ht;
        v    = (p / ht) % vt;
        o.pe = ((kk % div) == 0);
        o.de = (h < w) && (v < hh);
        o.hs = !((h >= w + hfp) && (h < w + hfp + hsp));
        o.vs = !((v >= hh + vfp) && (v < hh + vfp + vsp));
        o.x  = o.de ? 32'(h) : 32'd0;
        o.y  = o.de ? 32'(v) : 32'd0;
`ifdef VGA_FRAME_CNT_EN
        o.fc = 16'(off + p / (ht * vt));
`else
        o.fc = 16'(off & 64'd0);
`endif
        return o;
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d actual=%0d required=%0d", nm, k, act, exp);
        end
    endtask

    // Per-clk compare of every instance against the model, plus literal pins.
    initial begin
        forever begin
            @(negedge clk);
            chk("full", {a_pe, a_hs, a_vs, a_de, 32'(a_x), 32'(a_y), a_fc},
                model(2, 640, 16, 96, 48, 480, 10, 2, 33, k, 0));
            chk("small_div2", {b_pe, b_hs, b_vs, b_de, 32'(b_x), 32'(b_y), b_fc},
                model(2, SW, SHFP, SHS, SHBP, SH, SVFP, SVS, SVBP, k, fc_off));
            chk("small_div1", {c_pe, c_hs, c_vs, c_de, 32'(c_x), 32'(c_y), c_fc},
                model(1, SW, SHFP, SHS, SHBP, SH, SVFP, SVS, SVBP, k, 0));
            chk("small_div3", {d_pe, d_hs, d_vs, d_de, 32'(d_x), 32'(d_y), d_fc},
                model(3, SW, SHFP, SHS, SHBP, SH, SVFP, SVS, SVBP, k, 0));

            if (k == 0) begin
                pe_cnt = 0;
                hs_lo  = 0;
            end else if (k <= 1600) begin
                pe_cnt += 32'(a_pe);
                hs_lo  += 32'(!a_hs);
            end
            if (k == 1600) begin
                chk1("line_pe_count", pe_cnt, 800);
                chk1("line_hsync_low_clks", hs_lo, 192);
            end
            if (k == 1) begin
                chk1("first_de", 32'(a_de), 1);
                chk1("first_x", 32'(a_x), 0);
                chk1("first_pe", 32'(a_pe), 0);
                chk1("div1_first_pe", 32'(c_pe), 1);
            end
            if (k == 2) chk1("second_pe", 32'(a_pe), 1);
            if (k == 3) chk1("x_step1", 32'(a_x), 1);
            if (k == 1279) chk1("x_last", 32'(a_x), 639);
            if (k == 1281) chk1("de_off_640", 32'(a_de), 0);
            if (k == 1312) chk1("hsync_655", 32'(a_hs), 1);
            if (k == 1313) chk1("hsync_656", 32'(a_hs), 0);
            if (k == 1504) chk1("hsync_751", 32'(a_hs), 0);
            if (k == 1505) chk1("hsync_752", 32'(a_hs), 1);
            if (k == 1601) chk1("line2_y", 32'(a_y), 1);
            if (k == 896)  chk1("vsync_v13", 32'(b_vs), 1);
            if (k == 897)  chk1("vsync_v14", 32'(b_vs), 0);
            if (k == 1024) chk1("vsync_v15", 32'(b_vs), 0);
            if (k == 1025) chk1("vsync_v16", 32'(b_vs), 1);
`ifdef VGA_FRAME_CNT_EN
            if (fc_off == 0 && k == 6 * SFR)     chk1("frames_2", 32'(b_fc), 2);
            if (fc_off == 0 && k == 6 * SFR + 1) chk1("frames_3", 32'(b_fc), 3);
`endif
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        step(5);
        chk1("rst_de", 32'(a_de), 0);
        chk1("rst_hs", 32'(a_hs), 1);
        chk1("rst_vs", 32'(a_vs), 1);
        chk1("rst_x", 32'(a_x), 0);
        chk1("rst_y", 32'(a_y), 0);
        chk1("rst_pe", 32'(a_pe), 0);
        rst = 1'b1;
        step(6000);

        // one-clk reset at small-raster position h=15, v=10
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        for (int i = 0; i < 2000 && k != 671; i++) step(1);
        chk1("midframe_reach", 32'(k), 671);
        chk1("midframe_h", 32'(b_x), 15);
        rst = 1'b0;
        step(1);
        chk1("midframe_rst_de", 32'(b_de), 0);
        chk1("midframe_rst_hs", 32'(b_hs), 1);
        chk1("midframe_rst_vs", 32'(b_vs), 1);
        rst = 1'b1;
        step(1);
        chk1("midframe_resume_de", 32'(b_de), 1);
        chk1("midframe_resume_xy", {16'(b_x), 16'(b_y)}, 0);
        step(700);

`ifdef VGA_FRAME_CNT_EN
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(11);
        force u_small.frame_cnt_q = 16'hFFFF;
        fc_off = 65535;
        step(1);
        release u_small.frame_cnt_q;
        step(32'(2 * SFR) - 12);
        chk1("fc_preload_hold", 32'(b_fc), 65535);
        step(1);
        chk1("fc_wrap", 32'(b_fc), 0);
`endif

        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                rst    = 1'b0;
                fc_off = 0;
                step($urandom_range(1, 3));
                rst = 1'b1;
            end else begin
                step(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
